multiple_instructions: RTL and testbench
========================================

MULTIPLE_INSTRUCTIONS -- requirements
Module: multiple_instructions

Interface
REQ-001 SHALL have parameter PROGRAM_MEMORY_SIZE_WORDS, default 64: number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter DATA_MEMORY_SIZE_BYTES, default 256: number of bytes in the data memory.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have no other ports; behaviour is observable only through the internal signals named in REQ-006 to REQ-008.
REQ-006 SHALL contain instruction memory array program_memory[0:PROGRAM_MEMORY_SIZE_WORDS-1], 32 bits wide, loadable by hierarchical $readmemh.
REQ-007 SHALL expose internal signals pc (32-bit byte address) and instruction (32-bit, combinational program_memory[pc[31:2]]).
REQ-008 SHALL instantiate the datapath as single_instr, containing register file reg_mem with array memory[0:31] of 32-bit words.

Function
REQ-009 SHALL execute RV32I as a single-cycle core: each rising clk edge with reset high retires exactly one instruction.
REQ-010 SHALL support LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU instructions.
REQ-011 SHALL update pc to pc+4 by default, to pc+imm for taken branches and JAL, and to (rs1+imm)&~1 for JALR.
REQ-012 SHALL write rd = pc+4 for JAL/JALR, using the pre-jump pc.
REQ-013 SHALL keep x0 at 0 at all times; writes to x0 are discarded.
REQ-014 SHALL read rs1/rs2 combinationally and write rd on the same edge that updates pc, so the next instruction sees the new value.
REQ-015 SHALL perform ALU arithmetic modulo 2^32.
REQ-016 SHALL use the low 5 bits of the shift amount for shifts; SRA/SRAI SHALL sign-fill.
REQ-017 SHALL make SLT/SLTI signed compares and SLTU/SLTIU unsigned compares, with a 0/1 result.
REQ-018 SHALL use a separate little-endian, byte-addressed data memory of DATA_MEMORY_SIZE_BYTES, addressed by address modulo its size.
REQ-019 SHALL read the data memory combinationally; stores SHALL write on the clock edge.
REQ-020 SHALL sign-extend LB/LH results to 32 bits and zero-extend LBU/LHU results to 32 bits.
REQ-021 SHALL write only the addressed bytes for SB/SH; other bytes SHALL be unchanged.
REQ-022 SHALL support unaligned halfword/word access by byte-lane composition.
REQ-023 SHALL treat unsupported opcodes as no-ops: pc+4, with no register or memory write.
REQ-024 SHALL present X on instruction when pc is past the loaded program; behaviour after that is unspecified.

Reset
REQ-025 SHALL, while reset is low, asynchronously force pc=0 and clear all 32 registers to 0.
REQ-026 SHALL NOT clear program_memory or the data memory on reset.
REQ-027 SHALL, on the first rising edge after reset is released, execute the instruction at address 0.
REQ-028 SHALL, if reset is asserted mid-program, abort the current instruction with no register or memory write.

Verification
REQ-029 SHALL pass: addi x10,x0,5; addi x11,x0,-3; add x12,x10,x11 -> x12=2.
REQ-030 SHALL pass: sub x31,x12,x13 where x12=x13=2 -> x31=0.
REQ-031 SHALL pass: li x5,0x80; sb x5,0(x0); lbu x6,0(x0); lb x7,0(x0) -> x6=0x00000080 and x7=0xFFFFFF80.
REQ-032 SHALL pass: sw 0x12345678 at address 4, then lbu at addresses 4/5/6/7 -> 0x78, 0x56, 0x34, 0x12; lhu at 6 -> 0x1234.
REQ-033 SHALL pass: beq x0,x0,+8 -> skips the next instruction (pc 0->8); jal x1,+12 at pc 8 -> x1=12, pc=20.
REQ-034 SHALL pass: addi x0,x0,7 -> x0 stays 0.
REQ-035 SHALL pass: reset asserted after 3 instructions -> pc=0 and all registers 0 immediately.
REQ-036 SHALL keep x31=0 after every instruction of a self-checking program.

Source files
------------

// File: rtl/multiple_instructions.sv
// Single-cycle RV32I core. The top holds pc and the instruction memory; single_instr
// holds decode, ALU, register file (reg_mem) and the byte-addressed data memory.

module reg_mem (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic        rd_we,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data
);
   logic [31:0] memory [0:31];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 32; i++) memory[i] <= '0;
      end else if (rd_we && (rd_addr != 5'd0)) begin
         memory[rd_addr] <= rd_data;
      end
   end

   always_comb begin
      rs1_data = (rs1_addr == 5'd0) ? '0 : memory[rs1_addr];
      rs2_data = (rs2_addr == 5'd0) ? '0 : memory[rs2_addr];
   end
endmodule

module single_instr #(
   parameter int DATA_MEMORY_SIZE_BYTES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] instruction,
   output logic [31:0] pc_next
);
   localparam int DAW = (DATA_MEMORY_SIZE_BYTES > 1) ? $clog2(DATA_MEMORY_SIZE_BYTES) : 1;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'h37,
      OPC_AUIPC  = 7'h17,
      OPC_JAL    = 7'h6F,
      OPC_JALR   = 7'h67,
      OPC_BRANCH = 7'h63,
      OPC_LOAD   = 7'h03,
      OPC_STORE  = 7'h23,
      OPC_OPIMM  = 7'h13,
      OPC_OP     = 7'h33
   } opcode_e;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_data, rs2_data;
   logic        rd_we;
   logic [31:0] rd_data;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] ld_word;
   logic [DAW-1:0] lane_idx [4];
   logic [7:0]  data_memory [0:DATA_MEMORY_SIZE_BYTES-1];

   always_comb begin
      opcode   = instruction[6:0];
      rd_addr  = instruction[11:7];
      funct3   = instruction[14:12];
      rs1_addr = instruction[19:15];
      rs2_addr = instruction[24:20];
      imm_i    = {{20{instruction[31]}}, instruction[31:20]};
      imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      imm_b    = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
      imm_u    = {instruction[31:12], 12'd0};
      imm_j    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
   end

   reg_mem reg_mem (
      .clk      (clk),
      .reset    (reset),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_we    (rd_we),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f3, input logic alt);
      logic [31:0] r;
      case (f3)
         3'd0:    r = alt ? (a - b) : (a + b);
         3'd1:    r = a << b[4:0];
         3'd2:    r = {31'd0, $signed(a) < $signed(b)};
         3'd3:    r = {31'd0, a < b};
         3'd4:    r = a ^ b;
         3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   function automatic logic branch_taken(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3);
      logic t;
      case (f3)
         3'd0:    t = (a == b);
         3'd1:    t = (a != b);
         3'd4:    t = ($signed(a) < $signed(b));
         3'd5:    t = ($signed(a) >= $signed(b));
         3'd6:    t = (a < b);
         3'd7:    t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Each byte lane wraps independently, so unaligned accesses straddling the top
   // of the data memory continue at byte 0.
   function automatic logic [DAW-1:0] byte_index(input logic [31:0] addr, input logic [1:0] lane);
      logic [31:0] wrapped;
      wrapped = ((addr % 32'(DATA_MEMORY_SIZE_BYTES)) + 32'(lane)) % 32'(DATA_MEMORY_SIZE_BYTES);
      return wrapped[DAW-1:0];
   endfunction

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         lane_idx[k] = byte_index(mem_addr, 2'(k));
      end
      ld_word = {data_memory[lane_idx[3]], data_memory[lane_idx[2]],
                 data_memory[lane_idx[1]], data_memory[lane_idx[0]]};
   end

   always_comb begin
      rd_we     = 1'b0;
      rd_data   = '0;
      pc_next   = pc + 32'd4;
      mem_be    = '0;
      mem_wdata = rs2_data;
      mem_addr  = rs1_data + imm_i;
      case (opcode)
         OPC_LUI: begin
            rd_we   = 1'b1;
            rd_data = imm_u;
         end
         OPC_AUIPC: begin
            rd_we   = 1'b1;
            rd_data = pc + imm_u;
         end
         OPC_JAL: begin
            rd_we   = 1'b1;
            rd_data = pc + 32'd4;
            pc_next = pc + imm_j;
         end
         OPC_JALR: begin
            if (funct3 == 3'd0) begin
               rd_we   = 1'b1;
               rd_data = pc + 32'd4;
               pc_next = (rs1_data + imm_i) & ~32'd1;
            end
         end
         OPC_BRANCH: begin
            if (branch_taken(rs1_data, rs2_data, funct3)) pc_next = pc + imm_b;
         end
         OPC_LOAD: begin
            rd_we = 1'b1;
            case (funct3)
               3'd0:    rd_data = {{24{ld_word[7]}}, ld_word[7:0]};
               3'd1:    rd_data = {{16{ld_word[15]}}, ld_word[15:0]};
               3'd2:    rd_data = ld_word;
               3'd4:    rd_data = {24'd0, ld_word[7:0]};
               3'd5:    rd_data = {16'd0, ld_word[15:0]};
               default: rd_we   = 1'b0;
            endcase
         end
         OPC_STORE: begin
            mem_addr = rs1_data + imm_s;
            case (funct3)
               3'd0:    mem_be = 4'b0001;
               3'd1:    mem_be = 4'b0011;
               3'd2:    mem_be = 4'b1111;
               default: mem_be = 4'b0000;
            endcase
         end
         OPC_OPIMM: begin
            rd_we   = 1'b1;
            rd_data = alu(rs1_data, imm_i, funct3, (funct3 == 3'd5) && instruction[30]);
         end
         OPC_OP: begin
            rd_we   = 1'b1;
            rd_data = alu(rs1_data, rs2_data, funct3, instruction[30]);
         end
         default: ;
      endcase
   end

   // No reset on the array itself; stores are simply suppressed while reset is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (mem_be[k]) data_memory[lane_idx[k]] <= mem_wdata[8*k +: 8];
         end
      end
   end
endmodule

module multiple_instructions #(
   parameter int PROGRAM_MEMORY_SIZE_WORDS = 64,
   parameter int DATA_MEMORY_SIZE_BYTES    = 256
) (
   input logic clk,
   input logic reset
);
   localparam int PAW = (PROGRAM_MEMORY_SIZE_WORDS > 1) ? $clog2(PROGRAM_MEMORY_SIZE_WORDS) : 1;

   logic [31:0] program_memory [0:PROGRAM_MEMORY_SIZE_WORDS-1];
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic [29:0] word_addr;

   assign pc        = pc_q;
   assign word_addr = pc[31:2];

   always_comb begin
      instruction = 'x;
      if (word_addr < 30'(PROGRAM_MEMORY_SIZE_WORDS)) begin
         instruction = program_memory[word_addr[PAW-1:0]];
      end
   end

   single_instr #(
      .DATA_MEMORY_SIZE_BYTES (DATA_MEMORY_SIZE_BYTES)
   ) single_instr (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .instruction (instruction),
      .pc_next     (pc_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= '0;
      else        pc_q <= pc_d;
   end
endmodule

// File: tb/tb_multiple_instructions.sv
// Directed bench for multiple_instructions: a straight-line/branching program whose
// per-instruction results are tabulated, plus reset sequences.

module tb_multiple_instructions;
   localparam int OP_IMM = 7'h13, OP_REG = 7'h33, OP_LOAD = 7'h03, OP_LUI = 7'h37,
                  OP_AUIPC = 7'h17, OP_JALR = 7'h67;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   multiple_instructions #(
      .PROGRAM_MEMORY_SIZE_WORDS (64),
      .DATA_MEMORY_SIZE_BYTES    (256)
   ) dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      int          rd;
      logic [31:0] exp;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] ei(input int imm, input int rs1, input int f3, input int rd, input int op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] er(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] es(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] eu(input int imm, input int rd, input int op);
      return {imm[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] ej(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction

   function automatic void add(input logic [31:0] addr, input logic [31:0] instr, input int rd,
                               input logic [31:0] exp, input logic [31:0] exp_pc);
      vec_t v;
      v.addr = addr; v.instr = instr; v.rd = rd; v.exp = exp; v.exp_pc = exp_pc;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] regs_or();
      logic [31:0] acc = '0;
      for (int i = 0; i < 32; i++) acc |= dut.single_instr.reg_mem.memory[i];
      return acc;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;

      add(  0, eb(8, 0, 0, 0),                 31, 32'h0,        8);
      add(  8, ej(12, 1),                       1, 32'd12,      20);
      add( 20, ei(5, 0, 0, 10, OP_IMM),        10, 32'd5,       24);
      add( 24, ei(-3, 0, 0, 11, OP_IMM),       11, 32'hFFFFFFFD, 28);
      add( 28, er(0, 11, 10, 0, 12),           12, 32'd2,       32);
      add( 32, ei(2, 0, 0, 13, OP_IMM),        13, 32'd2,       36);
      add( 36, er(32, 13, 12, 0, 31),          31, 32'd0,       40);
      add( 40, ei(7, 0, 0, 0, OP_IMM),          0, 32'd0,       44);
      add( 44, ei(128, 0, 0, 5, OP_IMM),        5, 32'h80,      48);
      add( 48, es(0, 5, 0, 0),                 31, 32'd0,       52);
      add( 52, ei(0, 0, 4, 6, OP_LOAD),         6, 32'h80,      56);
      add( 56, ei(0, 0, 0, 7, OP_LOAD),         7, 32'hFFFFFF80, 60);
      add( 60, eu(32'h12345, 8, OP_LUI),        8, 32'h12345000, 64);
      add( 64, ei(32'h678, 8, 0, 8, OP_IMM),    8, 32'h12345678, 68);
      add( 68, es(4, 8, 0, 2),                 31, 32'd0,       72);
      add( 72, ei(4, 0, 4, 9, OP_LOAD),         9, 32'h78,      76);
      add( 76, ei(5, 0, 4, 9, OP_LOAD),         9, 32'h56,      80);
      add( 80, ei(6, 0, 4, 9, OP_LOAD),         9, 32'h34,      84);
      add( 84, ei(7, 0, 4, 9, OP_LOAD),         9, 32'h12,      88);
      add( 88, ei(6, 0, 5, 14, OP_LOAD),       14, 32'h1234,    92);
      add( 92, ei(5, 0, 1, 16, OP_LOAD),       16, 32'h3456,    96);
      add( 96, ei(4, 0, 2, 15, OP_LOAD),       15, 32'h12345678, 100);
      add(100, es(1, 11, 0, 1),                31, 32'd0,      104);
      add(104, ei(0, 0, 5, 17, OP_LOAD),       17, 32'hFD80,   108);
      add(108, ei(2, 0, 4, 17, OP_LOAD),       17, 32'hFF,     112);
      add(112, es(5, 5, 0, 0),                 31, 32'd0,      116);
      add(116, ei(4, 0, 2, 18, OP_LOAD),       18, 32'h12348078, 120);
      add(120, er(0, 10, 11, 2, 19),           19, 32'd1,      124);
      add(124, er(0, 10, 11, 3, 19),           19, 32'd0,      128);
      add(128, er(32, 13, 11, 5, 20),          20, 32'hFFFFFFFF, 132);
      add(132, er(0, 13, 11, 5, 20),           20, 32'h3FFFFFFF, 136);
      add(136, er(0, 8, 10, 1, 20),            20, 32'h05000000, 140);
      add(140, ei(-2, 11, 2, 21, OP_IMM),      21, 32'd1,      144);
      add(144, ei(-1, 10, 3, 21, OP_IMM),      21, 32'd1,      148);
      add(148, ei(15, 10, 4, 21, OP_IMM),      21, 32'hA,      152);
      add(152, ei(32'h404, 8, 5, 22, OP_IMM),  22, 32'h01234567, 156);
      add(156, ei(32'h401, 11, 5, 22, OP_IMM), 22, 32'hFFFFFFFE, 160);
      add(160, ei(31, 10, 1, 22, OP_IMM),      22, 32'h80000000, 164);
      add(164, er(0, 22, 22, 0, 23),           23, 32'd0,      168);
      add(168, eu(1, 24, OP_AUIPC),            24, 32'h10A8,   172);
      add(172, ei(200, 0, 0, 25, OP_IMM),      25, 32'd200,    176);
      add(176, ei(1, 25, 0, 26, OP_JALR),      26, 32'd180,    200);
      add(200, eb(8, 11, 10, 1),               31, 32'd0,      208);
      add(208, eb(8, 10, 11, 4),               31, 32'd0,      216);
      add(216, eb(8, 10, 11, 6),               31, 32'd0,      220);
      add(220, eb(8, 10, 11, 5),               31, 32'd0,      224);
      add(224, eb(8, 10, 11, 7),               31, 32'd0,      232);
      add(232, 32'hFFFFFFFF,                   31, 32'd0,      236);
      add(236, ei(255, 8, 7, 27, OP_IMM),      27, 32'h78,     240);
      add(240, er(0, 13, 10, 6, 27),           27, 32'd7,      244);
      add(244, er(0, 10, 11, 7, 27),           27, 32'd5,      248);
      add(248, er(0, 10, 11, 4, 28),           28, 32'hFFFFFFF8, 252);
      add(252, ei(-1, 0, 6, 28, OP_IMM),       28, 32'hFFFFFFFF, 256);

      // Slots never reached write x31, which every step checks stays zero.
      for (int i = 0; i < 64; i++) dut.program_memory[i] = ei(1, 0, 0, 31, OP_IMM);
      foreach (tbl[i]) dut.program_memory[tbl[i].addr[7:2]] = tbl[i].instr;

      #1 reset = 1'b0;
      #1;
      chk("reset_pc", dut.pc, 32'd0);
      chk("reset_regs", regs_or(), 32'd0);

      @(negedge clk) reset = 1'b1;
      foreach (tbl[i]) begin
         chk($sformatf("v%0d_pc_pre", i), dut.pc, tbl[i].addr);
         step();
         chk($sformatf("v%0d_x%0d", i, tbl[i].rd), dut.single_instr.reg_mem.memory[tbl[i].rd], tbl[i].exp);
         chk($sformatf("v%0d_pc", i), dut.pc, tbl[i].exp_pc);
         chk($sformatf("v%0d_x31", i), dut.single_instr.reg_mem.memory[31], 32'd0);
      end

      @(negedge clk) reset = 1'b0;
      #1;
      chk("rst2_pc", dut.pc, 32'd0);
      chk("rst2_regs", regs_or(), 32'd0);
      chk("rst2_dmem4", 32'(dut.single_instr.data_memory[4]), 32'h78);
      chk("rst2_dmem5", 32'(dut.single_instr.data_memory[5]), 32'h80);

      @(negedge clk) reset = 1'b1;
      step(); step(); step();
      chk("mid_pc", dut.pc, 32'd24);
      chk("mid_x1", dut.single_instr.reg_mem.memory[1], 32'd12);
      chk("mid_x10", dut.single_instr.reg_mem.memory[10], 32'd5);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_pc", dut.pc, 32'd0);
      chk("mid_rst_regs", regs_or(), 32'd0);

      step();
      chk("held_rst_pc", dut.pc, 32'd0);
      chk("held_rst_regs", regs_or(), 32'd0);

      @(negedge clk) reset = 1'b1;
      step();
      chk("first_after_rst_pc", dut.pc, 32'd8);
      step();
      chk("first_after_rst_x1", dut.single_instr.reg_mem.memory[1], 32'd12);
      chk("first_after_rst_pc2", dut.pc, 32'd20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
